// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin access to one registered
// OR/AND/XOR/NOR unit, one tagged transaction at a time.
module gate_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ*2-1:0]     op_sel,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [IDW:0]   NR   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic [IDW:0]     idx;
  logic             found;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [1:0]       s_arr [NREQ];

  // Unpack the per-requester operand buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = op_a[i*WIDTH +: WIDTH];
      b_arr[i] = op_b[i*WIDTH +: WIDTH];
      s_arr[i] = op_sel[2*i +: 2];
    end
  end

  // Round-robin scan from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (idx >= NR) idx = idx - NR;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  // Bitwise unit on the latched operands.
  always_comb begin
    unique case (sel_q)
      2'b00:   result = a_q | b_q;
      2'b01:   result = a_q & b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~(a_q | b_q);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: grant, one execute cycle, hold until handshake.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand latch, grant pulse, response and pointer updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
    end else begin
      gnt <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            a_q    <= a_arr[win];
            b_q    <= b_arr[win];
            sel_q  <= s_arr[win];
            gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            rsp_id <= win;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == LAST) ? '0 : rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
